// File: rtl/mem_arb_pkg.sv
// Purpose: shared types for the CPU memory arbiter (FSM states, bus transfer sizes).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_DATA = 3'd2,
    I_ADDR = 3'd3,
    I_DATA = 3'd4
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Purpose: serialises the MEM-stage data port and the fetch port onto one SRAM-like bus, data first.
// Latency: one idle cycle to arbitrate, then bus latency; stall drops the cycle after the last data_ok.
// Backpressure: the request is held until bus_addr_ok; mem_stall freezes the pipeline until all requested accesses finish.
module cpu_mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       d_done;
  logic       i_done;
  logic       need_d;
  logic       need_i;
  logic       d_resp;
  logic       i_resp;

  // A port still needs service if it is enabled and has not completed during this stalled cycle.
  assign need_d    = data_en & ~d_done;
  assign need_i    = inst_en & ~i_done;
  assign mem_stall = need_d | need_i;

  // Response strobes are only meaningful while waiting in the matching DATA state.
  assign d_resp = (state == D_DATA) & bus_data_ok;
  assign i_resp = (state == I_DATA) & bus_data_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: data is served before fetch because it belongs to the older instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (need_d) begin
          state_nxt = D_ADDR;
        end else if (need_i) begin
          state_nxt = I_ADDR;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) begin
          state_nxt = D_DATA;
        end
      end
      D_DATA: begin
        if (bus_data_ok) begin
          state_nxt = need_i ? I_ADDR : IDLE;
        end
      end
      I_ADDR: begin
        if (bus_addr_ok) begin
          state_nxt = I_DATA;
        end
      end
      I_DATA: begin
        if (bus_data_ok) begin
          state_nxt = need_d ? D_ADDR : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs come straight from the registered state; fields are zero when no request is driven.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = SZ_BYTE;
    bus_wstrb = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    case (state)
      D_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = |data_wen;
        bus_size  = data_size;
        bus_wstrb = data_wen;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end
      I_ADDR: begin
        bus_req   = 1'b1;
        bus_size  = SZ_WORD;
        bus_addr  = inst_addr;
      end
      default: begin
        bus_req   = 1'b0;
      end
    endcase
  end

  // Done flags: set on each completion, cleared on the edge where the pipeline advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_done <= 1'b0;
      i_done <= 1'b0;
    end else if (!mem_stall) begin
      d_done <= 1'b0;
      i_done <= 1'b0;
    end else begin
      if (d_resp) begin
        d_done <= 1'b1;
      end
      if (i_resp) begin
        i_done <= 1'b1;
      end
    end
  end

  // Returned words are latched; stores leave the load register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rdata <= 32'h0;
      inst_rdata <= 32'h0;
    end else begin
      if (d_resp && (data_wen == 4'b0000)) begin
        data_rdata <= bus_rdata;
      end
      if (i_resp) begin
        inst_rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Purpose: self-checking bench for cpu_mem_arbiter: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: the bench bus responder inserts random address and data wait states.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  cpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wen(data_wen), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  // One pending access of the current pipeline cycle, in service order.
  typedef struct {
    bit        is_d;
    bit        wr;
    bit [1:0]  size;
    bit [3:0]  wstrb;
    bit [31:0] addr;
    bit [31:0] wdata;
  } acc_t;

  acc_t      q[$];
  int        n_chk = 0;
  int        n_fail = 0;
  bit        in_resp = 1'b0;
  bit        issue_ok = 1'b0;
  bit        need_load = 1'b1;
  bit        adv = 1'b0;
  bit [31:0] m_drd = 32'h0;
  bit [31:0] m_ird = 32'h0;
  bit        p_rst, p_req, p_aok, p_dok;
  bit [31:0] p_rd;
  bit        dir_en, dir_aok, dir_dok;
  bit [31:0] dir_rd;
  bit        s_req, s_stall, s_wr;
  bit [1:0]  s_size;
  bit [3:0]  s_wstrb;
  bit [31:0] s_addr, s_wdata, s_drd, s_ird;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_inputs(input bit ie, input bit [31:0] ia, input bit de, input bit [3:0] dw,
                            input bit [1:0] ds, input bit [31:0] da, input bit [31:0] dwd);
    inst_en = ie; inst_addr = ia;
    data_en = de; data_wen = dw; data_size = ds; data_addr = da; data_wdata = dwd;
  endtask

  // One clock cycle: model compare and bus response at negedge, model update just after posedge.
  task automatic step();
    acc_t h;
    bit   er;
    @(negedge clk);
    if (need_load) begin
      q.delete();
      if (data_en) begin
        h.is_d = 1'b1; h.wr = |data_wen; h.size = data_size; h.wstrb = data_wen;
        h.addr = data_addr; h.wdata = data_wdata;
        q.push_back(h);
      end
      if (inst_en) begin
        h.is_d = 1'b0; h.wr = 1'b0; h.size = 2'd2; h.wstrb = 4'b0000;
        h.addr = inst_addr; h.wdata = 32'h0;
        q.push_back(h);
      end
      issue_ok = 1'b0;
      need_load = 1'b0;
    end
    er = issue_ok && !in_resp && (q.size() != 0);
    s_req = bus_req; s_stall = mem_stall; s_wr = bus_wr; s_size = bus_size;
    s_wstrb = bus_wstrb; s_addr = bus_addr; s_wdata = bus_wdata;
    s_drd = data_rdata; s_ird = inst_rdata;
    chk("mem_stall", mem_stall, q.size() != 0);
    chk("bus_req", bus_req, er);
    if (er) begin
      chk("bus_wr", bus_wr, q[0].wr);
      chk("bus_size", bus_size, q[0].size);
      chk("bus_wstrb", bus_wstrb, q[0].wstrb);
      chk("bus_addr", bus_addr, q[0].addr);
      if (q[0].wr) chk("bus_wdata", bus_wdata, q[0].wdata);
    end
    chk("data_rdata", data_rdata, m_drd);
    chk("inst_rdata", inst_rdata, m_ird);
    if (rst) begin
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
    end else if (dir_en) begin
      bus_addr_ok = dir_aok; bus_data_ok = dir_dok; bus_rdata = dir_rd;
    end else begin
      bus_addr_ok = er ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      bus_data_ok = in_resp ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus_rdata = $urandom;
    end
    p_rst = rst; p_req = er; p_aok = bus_addr_ok; p_dok = bus_data_ok; p_rd = bus_rdata;
    @(posedge clk);
    #1;
    adv = 1'b0;
    if (p_rst) begin
      q.delete();
      in_resp = 1'b0; issue_ok = 1'b0; m_drd = 32'h0; m_ird = 32'h0;
      need_load = 1'b1;
    end else begin
      adv = (q.size() == 0);
      if (p_req && p_aok) begin
        in_resp = 1'b1;
      end else if (in_resp && p_dok) begin
        if (q[0].is_d) begin
          if (!q[0].wr) m_drd = p_rd;
        end else begin
          m_ird = p_rd;
        end
        void'(q.pop_front());
        in_resp = 1'b0;
      end
      issue_ok = 1'b1;
      if (adv) need_load = 1'b1;
    end
  endtask

  task automatic bus(input bit aok, input bit dok, input bit [31:0] rd);
    dir_aok = aok; dir_dok = dok; dir_rd = rd;
  endtask

  initial begin
    bit [31:0] a;
    bit [1:0]  sz;
    bit        st;
    rst = 1'b1;
    set_inputs(0, 32'h0, 0, 4'h0, 2'd0, 32'h0, 32'h0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    dir_en = 1'b1;
    bus(0, 0, 32'h0);
    step(); step();
    chk("rst_bus_req", s_req, 0);   chk("rst_bus_wr", s_wr, 0);
    chk("rst_bus_size", s_size, 0); chk("rst_bus_wstrb", s_wstrb, 0);
    chk("rst_bus_addr", s_addr, 0); chk("rst_bus_wdata", s_wdata, 0);
    chk("rst_stall", s_stall, 0);   chk("rst_drd", s_drd, 0); chk("rst_ird", s_ird, 0);
    rst = 1'b0;

    // Idle: no enables for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_req", s_req, 0);
      chk("idle_stall", s_stall, 0);
    end

    // Fetch only, addr_ok at cycle 0 and data_ok at cycle 2.
    set_inputs(1, 32'hBFC00000, 0, 4'h0, 2'd2, 32'h0, 32'h0);
    bus(0, 0, 32'h0); step();
    chk("f_arb_stall", s_stall, 1); chk("f_arb_req", s_req, 0);
    bus(1, 0, 32'h0); step();
    chk("f_c0_req", s_req, 1); chk("f_c0_addr", s_addr, 32'hBFC00000);
    chk("f_c0_wr", s_wr, 0); chk("f_c0_size", s_size, 2); chk("f_c0_stall", s_stall, 1);
    bus(0, 0, 32'h0); step();
    chk("f_c1_stall", s_stall, 1); chk("f_c1_wr", s_wr, 0);
    bus(0, 1, 32'h3C080001); step();
    chk("f_c2_stall", s_stall, 1); chk("f_c2_wr", s_wr, 0);
    bus(0, 0, 32'h0); step();
    chk("f_c3_stall", s_stall, 0); chk("f_c3_ird", s_ird, 32'h3C080001);

    // Load and fetch in the same cycle: data goes first.
    set_inputs(1, 32'hBFC00004, 1, 4'h0, 2'd2, 32'h80000010, 32'h0);
    bus(0, 0, 32'h0); step();
    bus(1, 0, 32'h0); step();
    chk("lf_req1", s_req, 1); chk("lf_addr1", s_addr, 32'h80000010); chk("lf_wr1", s_wr, 0);
    bus(0, 1, 32'h11112222); step();
    chk("lf_wait_stall", s_stall, 1);
    bus(1, 0, 32'h0); step();
    chk("lf_req2", s_req, 1); chk("lf_addr2", s_addr, 32'hBFC00004);
    bus(0, 1, 32'h33334444); step();
    chk("lf_last_stall", s_stall, 1);
    bus(0, 0, 32'h0); step();
    chk("lf_stall_drop", s_stall, 0);
    chk("lf_drd", s_drd, 32'h11112222); chk("lf_ird", s_ird, 32'h33334444);

    // Byte store: strobes and size pass through, load register untouched.
    set_inputs(0, 32'h0, 1, 4'b0100, 2'd0, 32'h80000022, 32'h00AB0000);
    bus(0, 0, 32'h0); step();
    bus(1, 0, 32'h0); step();
    chk("st_wr", s_wr, 1); chk("st_wstrb", s_wstrb, 4'b0100);
    chk("st_size", s_size, 0); chk("st_wdata", s_wdata, 32'h00AB0000);
    bus(0, 1, 32'hDEADBEEF); step();
    bus(0, 0, 32'h0); step();
    chk("st_stall", s_stall, 0); chk("st_drd", s_drd, 32'h11112222);

    // Back-pressure: address not accepted for 5 cycles.
    set_inputs(0, 32'h0, 1, 4'h0, 2'd2, 32'h80000030, 32'h0);
    bus(0, 0, 32'h0); step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req", s_req, 1); chk("bp_addr", s_addr, 32'h80000030); chk("bp_stall", s_stall, 1);
    end
    bus(1, 0, 32'h0); step();
    bus(0, 1, 32'h55556666); step();
    bus(0, 0, 32'h0); step();
    chk("bp_stall_drop", s_stall, 0); chk("bp_drd", s_drd, 32'h55556666);

    // Reset while waiting for the data response; the load reissues afterwards.
    set_inputs(0, 32'h0, 1, 4'h0, 2'd2, 32'h80000040, 32'h0);
    bus(0, 0, 32'h0); step();
    bus(1, 0, 32'h0); step();
    bus(0, 0, 32'h0); step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("rr_req", s_req, 0); chk("rr_stall", s_stall, 1); chk("rr_drd", s_drd, 0);
    bus(1, 0, 32'h0); step();
    chk("rr_reissue", s_req, 1); chk("rr_addr", s_addr, 32'h80000040);
    bus(0, 1, 32'h77778888); step();
    bus(0, 0, 32'h0); step();
    chk("rr_done_stall", s_stall, 0); chk("rr_drd2", s_drd, 32'h77778888);

    // Randomized traffic with random wait states and occasional resets.
    dir_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (adv) begin
        sz = 2'($urandom_range(0, 2));
        st = $urandom_range(0, 1) == 1;
        a  = $urandom;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
        set_inputs($urandom_range(0, 3) != 0, {$urandom} & 32'hFFFF_FFFC,
                   $urandom_range(0, 1) == 1,
                   !st ? 4'h0 : (sz == 2'd0) ? 4'(4'b0001 << a[1:0]) :
                                (sz == 2'd1) ? 4'(4'b0011 << {a[1], 1'b0}) : 4'hF,
                   sz, a, $urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
